free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Circular FIFO of free physical registers for the R10K rename path.
//  Retire pushes up to N freed regs per cycle (the phys_regs_retiring / num_retiring pair from retire).
//  Dispatch pops up to N regs per cycle for new T_new allocation.
//  Branch mispredict recovery restores the allocation (head) pointer to a checkpoint.
// PARAMETERS
//  N          `N                 superscalar width (max push and max pop per cycle)
//  PHYS_REGS  `PHYS_REG_SZ_R10K  physical register count; power of two (64)
//  ARCH_REGS  32                 architectural regs; phys 0..ARCH_REGS-1 start mapped
// PORTS
//  clock              in   1                    single clock, rising edge
//  reset              in   1                    asynchronous, active-low
//  num_retiring       in   `NUM_SCALAR_BITS     regs pushed this cycle (0..N)
//  phys_regs_retiring in   N x PHYS_REG_IDX     freed regs; entry i valid iff i < num_retiring
//  num_dispatching    in   `NUM_SCALAR_BITS     regs popped this cycle (0..N)
//  regs_allocated     out  N x PHYS_REG_IDX     next N free regs from head (lookahead)
//  num_available      out  `NUM_SCALAR_BITS     min(free_count, N)
//  free_count         out  FL_PTR bits          entries currently free
//  head_ptr           out  FL_PTR               current head, for the branch checkpoint
//  restore_valid      in   1                    mispredict: reload head
//  restore_head_ptr   in   FL_PTR               checkpointed head value
// BEHAVIOUR
//  - Storage: PHYS_REGS entries. Pointers are $clog2(PHYS_REGS)+1 bits (MSB is the wrap bit).
//  - free_count = tail - head (mod 2^ptr width); never exceeds PHYS_REGS-1 (phys 0 is never free).
//  - Reset (async, reset==0):
//      entry k = ARCH_REGS+k for k < PHYS_REGS-ARCH_REGS; head=0; tail=PHYS_REGS-ARCH_REGS.
//      Outputs settle combinationally from that state: free_count=32, num_available=N,
//      regs_allocated[i]=ARCH_REGS+i.
//  - Pop: regs_allocated[i] = entry[(head+i) mod PHYS_REGS], combinational, zero latency.
//      At posedge, head += num_dispatching.
//  - Push: at posedge, entry[(tail+i) mod PHYS_REGS] = phys_regs_retiring[i] for i < num_retiring;
//      tail += num_retiring.
//  - No bypass: a reg pushed in cycle t is first visible on regs_allocated in cycle t+1.
//  - Push and pop in the same cycle are legal, including when free_count==0
//      (pop is 0 then, since num_available==0).
//  - Restore: restore_valid wins over pop. head <= restore_head_ptr and num_dispatching is ignored.
//      Push still happens the same cycle.
//      Next free_count = (tail+num_retiring) - restore_head_ptr.
//  - Protocol violations (assert; do not saturate or recover):
//      num_dispatching > num_available; num_retiring > N; pushing phys reg 0;
//      free_count+num_retiring-num_dispatching > PHYS_REGS-1.
//  - Wrap: all index math is mod PHYS_REGS. Wrap bit distinguishes full from empty.
//  - Reset asserted mid-operation: all state returns to reset values immediately.
//      In-flight push/pop that cycle is lost.
// STRUCTURE
//  - sys_defs.svh: FL_PTR typedef ($clog2(PHYS_REG_SZ_R10K)+1 bits) and FREE_LIST_INIT_COUNT.
//      Reuse PHYS_REG_IDX.
//  - Single module; no sub-module. Index generation is a generate loop over N.
// TESTING (N=3, PHYS_REGS=64, ARCH_REGS=32)
//  1. Release reset -> free_count=32, num_available=3, regs_allocated={32,33,34}, head_ptr=0.
//  2. num_dispatching=3 for 10 cycles -> free_count=2, num_available=2, regs_allocated[0..1]={62,63}.
//  3. From test 2, dispatch 2 -> count 0, avail 0.
//     Then retire {5,7} -> same cycle regs_allocated unchanged;
//     next cycle free_count=2, regs_allocated[0..1]={5,7}.
//  4. free_count=3, retire 3 {9,10,11} and dispatch 3 same cycle -> free_count stays 3,
//     next regs_allocated={9,10,11}.
//  5. Capture head_ptr=H, dispatch 3 twice, then restore_valid with head H plus retire 1 ->
//     head_ptr=H, free_count = count_at_capture+1.
//  6. Reset, then 500 cycles random balanced push/pop with pointer wrap, with reset pulsed at cycle 250 ->
//     model match, no duplicate reg ever allocated, reg 0 never allocated, state equals test 1 after reset.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared types and sizing for the R10K rename free list.
//   N                    superscalar width (max push / max pop per cycle)
//   PHYS_REGS            physical register count (power of two)
//   ARCH_REGS            architectural registers; phys 0..ARCH_REGS-1 start mapped
//   FREE_LIST_INIT_COUNT entries free out of reset
//   fl_ptr_t             free-list pointer, one extra MSB as wrap bit
package free_list_pkg;

  localparam int unsigned N                    = 3;
  localparam int unsigned PHYS_REGS            = 64;
  localparam int unsigned ARCH_REGS            = 32;
  localparam int unsigned IDX_W                = $clog2(PHYS_REGS);
  localparam int unsigned PTR_W                = IDX_W + 1;
  localparam int unsigned CNT_W                = $clog2(N + 1);
  localparam int unsigned FREE_LIST_INIT_COUNT = PHYS_REGS - ARCH_REGS;

  typedef logic [IDX_W-1:0] phys_reg_idx_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;
  typedef logic [CNT_W-1:0] num_scalar_t;

  // Storage slot reached by stepping 'off' entries past pointer p (drops the wrap bit).
  function automatic phys_reg_idx_t slot(input fl_ptr_t p, input int unsigned off);
    fl_ptr_t sum;
    sum = p + fl_ptr_t'(off);
    return phys_reg_idx_t'(sum);
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename-path bundle between retire/dispatch (master) and the free list (slave).
//   num_retiring / phys_regs_retiring  : freed regs pushed this cycle
//   num_dispatching                    : regs popped this cycle
//   regs_allocated / num_available     : lookahead of the next N free regs
//   free_count / head_ptr              : occupancy and head for branch checkpoints
//   restore_valid / restore_head_ptr   : mispredict head reload
interface free_list_if;
  import free_list_pkg::*;

  num_scalar_t             num_retiring;
  phys_reg_idx_t [N-1:0]   phys_regs_retiring;
  num_scalar_t             num_dispatching;
  phys_reg_idx_t [N-1:0]   regs_allocated;
  num_scalar_t             num_available;
  fl_ptr_t                 free_count;
  fl_ptr_t                 head_ptr;
  logic                    restore_valid;
  fl_ptr_t                 restore_head_ptr;

  modport master (
    output num_retiring, phys_regs_retiring, num_dispatching,
           restore_valid, restore_head_ptr,
    input  regs_allocated, num_available, free_count, head_ptr
  );

  modport slave (
    input  num_retiring, phys_regs_retiring, num_dispatching,
           restore_valid, restore_head_ptr,
    output regs_allocated, num_available, free_count, head_ptr
  );

endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical registers for the R10K rename path.
// Retire pushes up to N freed regs at the tail; dispatch pops up to N from the
// head; a mispredict reloads the head from a checkpoint.
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low
//   fl     : free_list_if.slave (push/pop/restore bundle)
module free_list
  import free_list_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  free_list_if.slave  fl
);

  phys_reg_idx_t          entries_q [PHYS_REGS];
  fl_ptr_t                head_q, head_d;
  fl_ptr_t                tail_q, tail_d;
  fl_ptr_t                free_count_c;
  phys_reg_idx_t [N-1:0]  wr_idx_c;
  logic          [N-1:0]  wr_en_c;

  // Wrap bit makes tail-head distinguish a full list from an empty one.
  assign free_count_c = tail_q - head_q;

  // Per-lane write slots and zero-latency read lookahead.
  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    assign wr_idx_c[i]          = slot(tail_q, i);
    assign wr_en_c[i]           = CNT_W'(i) < fl.num_retiring;
    assign fl.regs_allocated[i] = entries_q[slot(head_q, i)];
  end

  // Pointer advance; a restore overrides this cycle's pop, push still lands.
  always_comb begin
    head_d = head_q + fl_ptr_t'(fl.num_dispatching);
    tail_d = tail_q + fl_ptr_t'(fl.num_retiring);
    if (fl.restore_valid) begin
      head_d = fl.restore_head_ptr;
    end
  end

  // Pointer and storage state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(FREE_LIST_INIT_COUNT);
      for (int unsigned k = 0; k < PHYS_REGS; k++) begin
        entries_q[k] <= (k < FREE_LIST_INIT_COUNT) ? phys_reg_idx_t'(ARCH_REGS + k) : '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int unsigned i = 0; i < N; i++) begin
        if (wr_en_c[i]) begin
          entries_q[wr_idx_c[i]] <= fl.phys_regs_retiring[i];
        end
      end
    end
  end

  assign fl.free_count    = free_count_c;
  assign fl.head_ptr      = head_q;
  assign fl.num_available = (free_count_c >= fl_ptr_t'(N)) ? num_scalar_t'(N)
                                                           : num_scalar_t'(free_count_c);

`ifndef SYNTHESIS
  // Protocol checks: callers must never over-pop, over-push or free phys 0.
  fl_ptr_t next_count_c;
  assign next_count_c = tail_d - head_d;

  a_pop_le_avail: assert property (@(posedge clock) disable iff (!reset)
    !fl.restore_valid |-> (fl.num_dispatching <= fl.num_available));

  a_push_le_n: assert property (@(posedge clock) disable iff (!reset)
    fl.num_retiring <= num_scalar_t'(N));

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    next_count_c <= fl_ptr_t'(PHYS_REGS - 1));

  for (genvar i = 0; i < int'(N); i++) begin : g_chk
    a_no_reg0: assert property (@(posedge clock) disable iff (!reset)
      wr_en_c[i] |-> (fl.phys_regs_retiring[i] != '0));
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vector table plus randomized
// push/pop against a sequence-based reference model.
module tb_free_list;
  import free_list_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  free_list_if fl_if();

  free_list dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_ne(input string nm, input logic [31:0] act, input int bad);
    n_checks++;
    if (act === 32'(bad)) begin
      n_fail++;
      $display("FAIL %s: got %0d, must differ from %0d", nm, act, bad);
    end
  endtask

  task automatic drive(input int nd, input int nr, input int r0, input int r1,
                       input int r2, input bit rv, input int rh);
    fl_if.num_dispatching       = num_scalar_t'(nd);
    fl_if.num_retiring          = num_scalar_t'(nr);
    fl_if.phys_regs_retiring[0] = phys_reg_idx_t'(r0);
    fl_if.phys_regs_retiring[1] = phys_reg_idx_t'(r1);
    fl_if.phys_regs_retiring[2] = phys_reg_idx_t'(r2);
    fl_if.restore_valid         = rv;
    fl_if.restore_head_ptr      = fl_ptr_t'(rh);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " free_count"},    fl_if.free_count, 32);
    check({tag, " num_available"}, fl_if.num_available, 3);
    check({tag, " head_ptr"},      fl_if.head_ptr, 0);
    check({tag, " alloc0"},        fl_if.regs_allocated[0], 32);
    check({tag, " alloc1"},        fl_if.regs_allocated[1], 33);
    check({tag, " alloc2"},        fl_if.regs_allocated[2], 34);
  endtask

  // One cycle of stimulus plus the outputs expected while it is applied.
  typedef struct {
    int nd; int nr; int r0; int r1; int r2; bit rv; int rh;
    int e_cnt; int e_av; int a0; int a1; int a2; int amask; int e_head; bit nobyp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input int nd, input int nr, input int r0, input int r1,
                               input int r2, input bit rv, input int rh, input int cnt,
                               input int av, input int a0, input int a1, input int a2,
                               input int amask, input int hd, input bit nb);
    vec_t v;
    v.nd = nd; v.nr = nr; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.rv = rv; v.rh = rh;
    v.e_cnt = cnt; v.e_av = av; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.amask = amask; v.e_head = hd; v.nobyp = nb;
    return v;
  endfunction

  // Reference model: every reg ever freed, in order; head is an unbounded index.
  int seq[$];
  int h;
  int pool[$];
  bit inflight[PHYS_REGS];

  task automatic model_reset();
    seq.delete();
    pool.delete();
    for (int k = 0; k < 32; k++) seq.push_back(32 + k);
    h = 0;
    for (int k = 0; k < PHYS_REGS; k++) inflight[k] = (k < 32);
    for (int k = 1; k < 32; k++) pool.push_back(k);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    // Directed sequence: reset, drain, empty push, balanced push/pop, restore.
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  32, 3, 32, 33, 34, 7, 0, 0));
    for (int j = 0; j < 10; j++)
      vecs.push_back(mkv(3, 0, 0, 0, 0, 0, 0, 32 - 3*j, 3, 32 + 3*j, 33 + 3*j, 34 + 3*j, 7, 3*j, 0));
    vecs.push_back(mkv(2, 0, 0, 0, 0, 0, 0,    2, 2, 62, 63, 0, 3, 30, 0));
    vecs.push_back(mkv(0, 2, 5, 7, 0, 0, 0,    0, 0, 0, 0, 0, 0, 32, 1));
    vecs.push_back(mkv(0, 1, 20, 0, 0, 0, 0,   2, 2, 5, 7, 0, 3, 32, 0));
    vecs.push_back(mkv(3, 3, 9, 10, 11, 0, 0,  3, 3, 5, 7, 20, 7, 32, 0));
    vecs.push_back(mkv(0, 3, 12, 13, 14, 0, 0, 3, 3, 9, 10, 11, 7, 35, 0));
    vecs.push_back(mkv(3, 0, 0, 0, 0, 0, 0,    6, 3, 9, 10, 11, 7, 35, 0));
    vecs.push_back(mkv(3, 0, 0, 0, 0, 0, 0,    3, 3, 12, 13, 14, 7, 38, 0));
    vecs.push_back(mkv(0, 1, 15, 0, 0, 1, 35,  0, 0, 0, 0, 0, 0, 41, 0));
    vecs.push_back(mkv(3, 0, 0, 0, 0, 1, 36,   7, 3, 9, 10, 11, 7, 35, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0,    6, 3, 10, 11, 12, 7, 36, 0));

    #12;
    check_reset_state("in_reset");
    @(negedge clock);
    reset = 1'b1;
    step();

    foreach (vecs[v]) begin
      drive(vecs[v].nd, vecs[v].nr, vecs[v].r0, vecs[v].r1, vecs[v].r2, vecs[v].rv, vecs[v].rh);
      check($sformatf("v%0d free_count", v),    fl_if.free_count,    vecs[v].e_cnt);
      check($sformatf("v%0d num_available", v), fl_if.num_available, vecs[v].e_av);
      check($sformatf("v%0d head_ptr", v),      fl_if.head_ptr,      vecs[v].e_head);
      if ((vecs[v].amask & 1) != 0) check($sformatf("v%0d alloc0", v), fl_if.regs_allocated[0], vecs[v].a0);
      if ((vecs[v].amask & 2) != 0) check($sformatf("v%0d alloc1", v), fl_if.regs_allocated[1], vecs[v].a1);
      if ((vecs[v].amask & 4) != 0) check($sformatf("v%0d alloc2", v), fl_if.regs_allocated[2], vecs[v].a2);
      if (vecs[v].nobyp) check_ne($sformatf("v%0d no_bypass", v), fl_if.regs_allocated[0], vecs[v].r0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Randomized balanced traffic with a reset pulse mid-run.
    reset = 1'b0;
    #1;
    check_reset_state("rnd_reset");
    step();
    reset = 1'b1;
    model_reset();

    for (int cyc = 0; cyc < 500; cyc++) begin
      int cnt, av, nd, nr, maxr, idx, r;
      int regs[3];
      cnt = seq.size() - h;
      av  = (cnt < 3) ? cnt : 3;

      if (cyc == 250) begin
        drive(av, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        check_reset_state("mid_reset");
        step();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        check_reset_state("after_mid_reset");
        continue;
      end

      check("rnd free_count",    fl_if.free_count,    cnt);
      check("rnd num_available", fl_if.num_available, av);
      check("rnd head_ptr",      fl_if.head_ptr,      h % 128);
      for (int i = 0; i < av; i++) begin
        r = seq[h + i];
        check($sformatf("rnd alloc%0d", i), fl_if.regs_allocated[i], r);
        check_ne($sformatf("rnd alloc%0d reg0", i), fl_if.regs_allocated[i], 0);
      end

      nd   = $urandom_range(0, av);
      maxr = (pool.size() < 3) ? pool.size() : 3;
      nr   = $urandom_range(0, maxr);
      for (int i = 0; i < 3; i++) regs[i] = 0;
      for (int i = 0; i < nr; i++) begin
        idx = $urandom_range(0, pool.size() - 1);
        regs[i] = pool[idx];
        pool.delete(idx);
      end
      for (int i = 0; i < nd; i++)
        check($sformatf("rnd dup alloc%0d", i), 32'(inflight[seq[h + i]]), 0);

      drive(nd, nr, regs[0], regs[1], regs[2], 0, 0);
      step();

      for (int i = 0; i < nr; i++) begin
        seq.push_back(regs[i]);
        inflight[regs[i]] = 1'b0;
      end
      for (int i = 0; i < nd; i++) begin
        inflight[seq[h + i]] = 1'b1;
        pool.push_back(seq[h + i]);
      end
      h += nd;
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
